// File: rtl/fu_dpi_pipe_if.sv
// fu_dpi_pipe_if
//   Issue and result bus of the data-processing-immediate functional unit.
//   slave  : the functional unit itself.
//   master : the issue-queue / writeback-arbiter side driving it.
// Signals:
//   flush                          squash everything in flight and queued
//   inst_valid/fu_ready            issue handshake (fu_ready is credit based)
//   inst, inst_id, pc, op0         instruction word, tag, PC and Rn/Rd source
//   out_prn, out_prn_valid         destination PRNs per lane (0=Rd, 1=unused, 2=NZCV)
//   fu_out_valid/fu_out_ready      result handshake at the output queue head
//   fu_out_inst_id, fu_out_prn,
//   fu_out_prn_valid, fu_out_data,
//   fu_out_data_valid,
//   fu_out_illegal                 head entry fields
interface fu_dpi_pipe_if #(
    parameter int PRN_W = 7,
    parameter int ID_W  = 6,
    parameter int N_OUT = 3
) ();
    logic                   flush;
    logic                   inst_valid;
    logic                   fu_ready;
    logic [31:0]            inst;
    logic [ID_W-1:0]        inst_id;
    logic [63:0]            pc;
    logic [63:0]            op0;
    logic [N_OUT*PRN_W-1:0] out_prn;
    logic [N_OUT-1:0]       out_prn_valid;
    logic                   fu_out_valid;
    logic                   fu_out_ready;
    logic [ID_W-1:0]        fu_out_inst_id;
    logic [N_OUT*PRN_W-1:0] fu_out_prn;
    logic [N_OUT-1:0]       fu_out_prn_valid;
    logic [N_OUT*64-1:0]    fu_out_data;
    logic [N_OUT-1:0]       fu_out_data_valid;
    logic                   fu_out_illegal;

    modport slave (
        input  flush, inst_valid, inst, inst_id, pc, op0, out_prn, out_prn_valid,
        input  fu_out_ready,
        output fu_ready, fu_out_valid, fu_out_inst_id, fu_out_prn, fu_out_prn_valid,
        output fu_out_data, fu_out_data_valid, fu_out_illegal
    );

    modport master (
        output flush, inst_valid, inst, inst_id, pc, op0, out_prn, out_prn_valid,
        output fu_out_ready,
        input  fu_ready, fu_out_valid, fu_out_inst_id, fu_out_prn, fu_out_prn_valid,
        input  fu_out_data, fu_out_data_valid, fu_out_illegal
    );
endinterface

// File: rtl/fu_dpi_pipe.sv
// fu_dpi_pipe
//   Data-processing-immediate functional unit: MOVZ/MOVN/MOVK, ADR/ADRP and
//   ADD/ADDS/SUB/SUBS (immediate), with NZCV on lane 2. Results are computed
//   at issue, delayed through LAT-1 pipeline stages and written into a
//   QDEPTH-entry output FIFO. Issue readiness is credit based: every accepted
//   instruction holds a credit until it is popped from the FIFO, so the
//   pipeline never stalls and always finds a free FIFO slot.
// Ports:
//   clk  rising-edge clock
//   rst  asynchronous active-high reset
//   bus  fu_dpi_pipe_if slave modport (issue, flush and result queue head)
module fu_dpi_pipe #(
    parameter int LAT    = 1,
    parameter int QDEPTH = 2,
    parameter int PRN_W  = 7,
    parameter int ID_W   = 6,
    parameter int N_OUT  = 3
) (
    input  logic         clk,
    input  logic         rst,
    fu_dpi_pipe_if.slave bus
);
    localparam int CNT_W = $clog2(QDEPTH + 1);
    localparam int PTR_W = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
    localparam logic [CNT_W-1:0] QDEPTH_C = CNT_W'(QDEPTH);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(QDEPTH - 1);

    typedef struct packed {
        logic [ID_W-1:0]        id;
        logic [N_OUT*PRN_W-1:0] prn;
        logic [N_OUT-1:0]       prn_v;
        logic [N_OUT*64-1:0]    data;
        logic [N_OUT-1:0]       data_v;
        logic                   illegal;
    } entry_t;

    // Circular pointer advance for the output FIFO.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (p == PTR_LAST) begin
            return '0;
        end else begin
            return p + PTR_W'(1);
        end
    endfunction

    logic [CNT_W-1:0] occ_q, occ_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [PTR_W-1:0] wr_q, rd_q;
    entry_t           mem_q [QDEPTH];

    logic             accept_s;
    logic             pop_s;
    logic             head_vld_s;
    entry_t           head_s;
    entry_t           new_s;
    logic             push_vld_s;
    entry_t           push_ent_s;

    logic [63:0]      rd_s;
    logic [3:0]       nzcv_s;
    logic             legal_s;
    logic             s_op_s;
    logic [5:0]       hw_sh_s;
    logic [63:0]      wide_imm_s;
    logic [63:0]      imm21_s;
    logic [63:0]      aimm_s;
    logic [63:0]      addend_s;
    logic [64:0]      sum_s;
    logic [N_OUT-1:0] produces_s;
    logic             unused_ok_s;

    // Rd field is renamed upstream; the architectural register number is not needed here.
    assign unused_ok_s = ^bus.inst[4:0];

    // Credits: one per in-flight or queued instruction; readiness depends on occ only.
    assign bus.fu_ready = (occ_q < QDEPTH_C);
    assign accept_s     = bus.inst_valid && bus.fu_ready;
    assign head_vld_s   = (cnt_q != '0);
    assign pop_s        = head_vld_s && bus.fu_out_ready;

    // Decode and execute the instruction presented at the issue port.
    always_comb begin
        rd_s       = 64'd0;
        nzcv_s     = 4'd0;
        legal_s    = 1'b0;
        s_op_s     = 1'b0;
        hw_sh_s    = {bus.inst[22:21], 4'b0000};
        wide_imm_s = {48'd0, bus.inst[20:5]} << hw_sh_s;
        imm21_s    = {{43{bus.inst[23]}}, bus.inst[23:5], bus.inst[30:29]};
        aimm_s     = bus.inst[22] ? {40'd0, bus.inst[21:10], 12'd0} : {52'd0, bus.inst[21:10]};
        // Subtraction is op0 + ~imm + 1, so the carry out is already NOT borrow.
        addend_s   = bus.inst[30] ? ~aimm_s : aimm_s;
        sum_s      = {1'b0, bus.op0} + {1'b0, addend_s} + {64'd0, bus.inst[30]};
        if (bus.inst[31:23] == 9'b110100101) begin
            legal_s = 1'b1;
            rd_s    = wide_imm_s;
        end else if (bus.inst[31:23] == 9'b100100101) begin
            legal_s = 1'b1;
            rd_s    = ~wide_imm_s;
        end else if (bus.inst[31:23] == 9'b111100101) begin
            legal_s = 1'b1;
            rd_s    = (bus.op0 & ~({48'd0, 16'hFFFF} << hw_sh_s)) | wide_imm_s;
        end else if (bus.inst[28:24] == 5'b10000) begin
            legal_s = 1'b1;
            if (bus.inst[31]) begin
                rd_s = {bus.pc[63:12], 12'd0} + {imm21_s[51:0], 12'd0};
            end else begin
                rd_s = bus.pc + imm21_s;
            end
        end else if (bus.inst[31] && (bus.inst[28:23] == 6'b100010)) begin
            legal_s = 1'b1;
            s_op_s  = bus.inst[29];
            rd_s    = sum_s[63:0];
            if (bus.inst[29]) begin
                // Overflow: both addends share a sign that the result does not.
                nzcv_s = {sum_s[63], (sum_s[63:0] == 64'd0), sum_s[64],
                          (bus.op0[63] == addend_s[63]) && (sum_s[63] != bus.op0[63])};
            end else begin
                nzcv_s = 4'd0;
            end
        end else begin
            legal_s = 1'b0;
            rd_s    = 64'd0;
        end
    end

    // Pack the decoded result into a queue entry.
    always_comb begin
        new_s                 = '0;
        produces_s            = '0;
        produces_s[0]         = legal_s;
        produces_s[2]         = s_op_s;
        new_s.id              = bus.inst_id;
        new_s.prn             = bus.out_prn;
        new_s.prn_v           = bus.out_prn_valid;
        new_s.data[63:0]      = rd_s;
        new_s.data[128 +: 64] = {60'd0, nzcv_s};
        new_s.data_v          = bus.out_prn_valid & produces_s;
        new_s.illegal         = !legal_s;
    end

    generate
        if (LAT > 1) begin : g_pipe
            entry_t           stg_q [LAT-1];
            logic [LAT-2:0]   vld_q;

            // Fixed-latency delay line between issue and the output queue.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    vld_q <= '0;
                    for (int i = 0; i < LAT - 1; i++) begin
                        stg_q[i] <= '0;
                    end
                end else if (bus.flush) begin
                    vld_q <= '0;
                end else begin
                    vld_q[0] <= accept_s;
                    stg_q[0] <= new_s;
                    for (int i = 1; i < LAT - 1; i++) begin
                        vld_q[i] <= vld_q[i-1];
                        stg_q[i] <= stg_q[i-1];
                    end
                end
            end

            assign push_vld_s = vld_q[LAT-2];
            assign push_ent_s = stg_q[LAT-2];
        end else begin : g_nopipe
            assign push_vld_s = accept_s;
            assign push_ent_s = new_s;
        end
    endgenerate

    // Next occupancy values; flush wipes all credits and queued entries.
    always_comb begin
        occ_d = occ_q;
        cnt_d = cnt_q;
        if (bus.flush) begin
            occ_d = '0;
            cnt_d = '0;
        end else begin
            occ_d = occ_q + CNT_W'(accept_s) - CNT_W'(pop_s);
            cnt_d = cnt_q + CNT_W'(push_vld_s) - CNT_W'(pop_s);
        end
    end

    // Output FIFO storage, pointers and credit counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            occ_q <= '0;
            cnt_q <= '0;
            wr_q  <= '0;
            rd_q  <= '0;
            for (int i = 0; i < QDEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (bus.flush) begin
            occ_q <= '0;
            cnt_q <= '0;
            wr_q  <= '0;
            rd_q  <= '0;
        end else begin
            occ_q <= occ_d;
            cnt_q <= cnt_d;
            if (push_vld_s) begin
                mem_q[wr_q] <= push_ent_s;
                wr_q        <= ptr_inc(wr_q);
            end
            if (pop_s) begin
                rd_q <= ptr_inc(rd_q);
            end
        end
    end

    // Head fields read as zero whenever the queue is empty, so no stale entry leaks out.
    always_comb begin
        head_s = '0;
        if (head_vld_s) begin
            head_s = mem_q[rd_q];
        end else begin
            head_s = '0;
        end
    end

    assign bus.fu_out_valid      = head_vld_s;
    assign bus.fu_out_inst_id    = head_s.id;
    assign bus.fu_out_prn        = head_s.prn;
    assign bus.fu_out_prn_valid  = head_s.prn_v;
    assign bus.fu_out_data       = head_s.data;
    assign bus.fu_out_data_valid = head_s.data_v;
    assign bus.fu_out_illegal    = head_s.illegal;
endmodule
